// File: rtl/decode_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_sched_pkg
// Description : Shared constants for the decoder job scheduler: FSM state
//               encoding, requester select codes and input-RAM geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_sched_pkg;

  // Input-RAM geometry defaults (mirror the decoder wrapper's params.v)
  localparam int OUT_D_SIZE_DEF = 32;
  localparam int OUT_DEPTH_DEF  = 10;

  // Scheduler FSM encoding
  localparam int         ST_W     = 3;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  // Requester select codes; the value doubles as the decoder `mode` bit
  localparam logic SEL_RQ  = 1'b1;
  localparam logic SEL_RND = 1'b0;

endpackage
`default_nettype wire

// File: rtl/decode_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : decode_rr_arb
// Description : Two-way round-robin grant between the Rq and Rounded decode
//               clients. Remembers which client finished last and favours the
//               other one when both request together.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_rr_arb
  import decode_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_rq,
  input  logic i_req_rnd,
  input  logic i_upd,      // a job has just completed
  input  logic i_served,   // select code of the completed job
  output logic o_any,      // at least one client requesting
  output logic o_sel       // client to grant (valid when o_any)
);

  logic r_last_served;

  // Track the last completed client; Rounded at reset so Rq wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_served <= SEL_RND;
    end else if (i_upd) begin
      r_last_served <= i_served;
    end
  end

  // Single requester wins outright; on a tie the one not served last wins
  always_comb begin
    o_any = i_req_rq | i_req_rnd;
    if (i_req_rq && i_req_rnd) begin
      o_sel = ~r_last_served;
    end else begin
      o_sel = i_req_rq ? SEL_RQ : SEL_RND;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_sched.sv
`default_nettype none
// ============================================================================
// Module      : decode_sched
// Description : Job scheduler in front of the shared mode-switched decoder.
//               Arbitrates Rq/Rounded clients, drives start/mode, watches done
//               with a watchdog and blocks host input-RAM writes during a job.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_sched
  import decode_sched_pkg::*;
#(
  parameter int              TO_W       = 16,
  parameter logic [TO_W-1:0] TO_MAX     = 16'hFFFF,
  parameter int              OUT_D_SIZE = OUT_D_SIZE_DEF,
  parameter int              OUT_DEPTH  = OUT_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_rq,
  input  logic                  req_rnd,
  output logic                  ack_rq,
  output logic                  ack_rnd,
  output logic                  fin_rq,
  output logic                  fin_rnd,
  output logic                  busy,
  output logic                  err,
  output logic [TO_W-1:0]       last_lat,
  output logic                  dec_start,
  output logic                  dec_mode,
  input  logic                  dec_done,
  input  logic                  h_we,
  input  logic [OUT_DEPTH-1:0]  h_aw,
  input  logic [OUT_D_SIZE-1:0] h_dw,
  output logic                  rp_we,
  output logic [OUT_DEPTH-1:0]  rp_aw,
  output logic [OUT_D_SIZE-1:0] rp_dw,
  output logic                  wr_rej
);

  localparam logic [TO_W-1:0] C_WD_LAST = TO_MAX - 1'b1;

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_nxt;
  logic            r_sel;
  logic            r_dec_start;
  logic [TO_W-1:0] r_wd;
  logic [TO_W-1:0] r_last_lat;
  logic            r_wr_rej;
  logic            w_any;
  logic            w_arb_sel;
  logic            w_idle;
  logic            w_grant;
  logic            w_done_st;

  decode_rr_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req_rq  (req_rq),
    .i_req_rnd (req_rnd),
    .i_upd     (w_done_st),
    .i_served  (r_sel),
    .o_any     (w_any),
    .o_sel     (w_arb_sel)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; done is only looked at while the job is running
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (dec_done) begin
          w_state_nxt = ST_DONE;
        end else if (r_wd == C_WD_LAST) begin
          w_state_nxt = ST_ERR;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_ERR:   w_state_nxt = ST_ERR;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state, plus the host write gate
  always_comb begin
    w_idle    = (r_state == ST_IDLE);
    w_done_st = (r_state == ST_DONE);
    w_grant   = w_idle & w_any;
    ack_rq    = (r_state == ST_START) & (r_sel == SEL_RQ);
    ack_rnd   = (r_state == ST_START) & (r_sel == SEL_RND);
    fin_rq    = w_done_st & (r_sel == SEL_RQ);
    fin_rnd   = w_done_st & (r_sel == SEL_RND);
    busy      = ~w_idle;
    err       = (r_state == ST_ERR);
    rp_we     = h_we & w_idle;
    rp_aw     = h_aw;
    rp_dw     = h_dw;
  end

  // Job datapath: latched select/mode, start pulse, watchdog, latency, reject
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel       <= SEL_RND;
      r_dec_start <= 1'b0;
      r_wd        <= '0;
      r_last_lat  <= '0;
      r_wr_rej    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_sel <= w_arb_sel;
      end
      // Registered so the decoder sees start one cycle after the ack
      r_dec_start <= (r_state == ST_START);
      if (r_state == ST_START) begin
        r_wd <= '0;
      end else if (r_state == ST_RUN) begin
        r_wd <= r_wd + 1'b1;
      end
      if ((r_state == ST_RUN) && dec_done) begin
        r_last_lat <= r_wd + 1'b1;
      end
      r_wr_rej <= h_we & ~w_idle;
    end
  end

  assign dec_start = r_dec_start;
  assign dec_mode  = r_sel;
  assign last_lat  = r_last_lat;
  assign wr_rej    = r_wr_rej;

endmodule
`default_nettype wire

// File: tb/tb_decode_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_sched
// Description : Directed self-checking bench for decode_sched. dut_a uses the
//               default watchdog limit, dut_b a 16-cycle limit for timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_sched;
  import decode_sched_pkg::*;

  localparam int DW = OUT_D_SIZE_DEF;
  localparam int AW = OUT_DEPTH_DEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rst_b = 1'b1;
  logic          req_rq = 1'b0, req_rnd = 1'b0, dec_done = 1'b0, h_we = 1'b0;
  logic [AW-1:0] h_aw = '0;
  logic [DW-1:0] h_dw = '0;

  logic          ack_rq, ack_rnd, fin_rq, fin_rnd, busy, err, dec_start, dec_mode;
  logic          rp_we, wr_rej;
  logic [15:0]   last_lat;
  logic [AW-1:0] rp_aw;
  logic [DW-1:0] rp_dw;

  logic          b_ack_rq, b_ack_rnd, b_fin_rq, b_fin_rnd, b_busy, b_err;
  logic          b_dec_start, b_dec_mode, b_rp_we, b_wr_rej;
  logic [15:0]   b_last_lat;
  logic [AW-1:0] b_rp_aw;
  logic [DW-1:0] b_rp_dw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_sched dut_a (
    .clk(clk), .rst(rst), .req_rq(req_rq), .req_rnd(req_rnd),
    .ack_rq(ack_rq), .ack_rnd(ack_rnd), .fin_rq(fin_rq), .fin_rnd(fin_rnd),
    .busy(busy), .err(err), .last_lat(last_lat), .dec_start(dec_start),
    .dec_mode(dec_mode), .dec_done(dec_done), .h_we(h_we), .h_aw(h_aw),
    .h_dw(h_dw), .rp_we(rp_we), .rp_aw(rp_aw), .rp_dw(rp_dw), .wr_rej(wr_rej)
  );

  decode_sched #(.TO_MAX(16'd16)) dut_b (
    .clk(clk), .rst(rst_b), .req_rq(req_rq), .req_rnd(req_rnd),
    .ack_rq(b_ack_rq), .ack_rnd(b_ack_rnd), .fin_rq(b_fin_rq), .fin_rnd(b_fin_rnd),
    .busy(b_busy), .err(b_err), .last_lat(b_last_lat), .dec_start(b_dec_start),
    .dec_mode(b_dec_mode), .dec_done(dec_done), .h_we(h_we), .h_aw(h_aw),
    .h_dw(h_dw), .rp_we(b_rp_we), .rp_aw(b_rp_aw), .rp_dw(b_rp_dw), .wr_rej(b_wr_rej)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Complete job on dut_a: grant, start, len RUN cycles, done, back to IDLE
  task automatic run_job(input logic exp_rq, input int len, input logic drop);
    tick();
    chk("ack_rq", ack_rq, exp_rq);
    chk("ack_rnd", ack_rnd, !exp_rq);
    chk("mode_at_grant", dec_mode, exp_rq);
    chk("start_in_START", dec_start, 0);
    if (drop) begin
      req_rq  = 1'b0;
      req_rnd = 1'b0;
    end
    tick();
    chk("dec_start", dec_start, 1);
    chk("ack_cleared", ack_rq | ack_rnd, 0);
    for (int i = 1; i < len; i++) begin
      tick();
      chk("mode_hold", dec_mode, exp_rq);
      chk("run_quiet", dec_start | fin_rq | fin_rnd, 0);
    end
    dec_done = 1'b1;
    tick();
    chk("fin_rq", fin_rq, exp_rq);
    chk("fin_rnd", fin_rnd, !exp_rq);
    chk("last_lat", last_lat, len);
    chk("mode_done", dec_mode, exp_rq);
    dec_done = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("fin_cleared", fin_rq | fin_rnd, 0);
  endtask

  typedef struct {
    logic exp_rq;
    int   len;
  } job_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] aw;
    logic [DW-1:0] dw;
    logic          exp_we;
  } wg_t;

  job_t jobs [3];
  wg_t  wvec [4];

  initial begin
    jobs[0] = '{exp_rq: 1'b1, len: 5};
    jobs[1] = '{exp_rq: 1'b0, len: 3};
    jobs[2] = '{exp_rq: 1'b1, len: 7};
    wvec[0] = '{we: 1'b1, aw: 10'd5,    dw: 32'hDEADBEEF, exp_we: 1'b1};
    wvec[1] = '{we: 1'b0, aw: 10'd5,    dw: 32'h12345678, exp_we: 1'b0};
    wvec[2] = '{we: 1'b1, aw: 10'd0,    dw: 32'h00000001, exp_we: 1'b1};
    wvec[3] = '{we: 1'b1, aw: 10'd1023, dw: 32'hFFFFFFFF, exp_we: 1'b1};

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_mode", dec_mode, 0);
    chk("rst_start", dec_start, 0);
    chk("rst_lat", last_lat, 0);
    chk("rst_pulses", ack_rq | ack_rnd | fin_rq | fin_rnd | wr_rej, 0);

    // Single Rq job, done in its 40th RUN cycle
    req_rq = 1'b1;
    run_job(1'b1, 40, 1'b1);

    // Both requesting across three jobs: Rq, Rnd, Rq
    rst = 1'b1; tick(); rst = 1'b0;
    req_rq = 1'b1; req_rnd = 1'b1;
    for (int j = 0; j < 3; j++) begin
      run_job(jobs[j].exp_rq, jobs[j].len, 1'b0);
    end
    req_rq = 1'b0; req_rnd = 1'b0;
    tick();

    // Host writes while IDLE pass straight through
    for (int k = 0; k < 4; k++) begin
      h_we = wvec[k].we; h_aw = wvec[k].aw; h_dw = wvec[k].dw;
      #1;
      chk("idle_rp_we", rp_we, wvec[k].exp_we);
      chk("idle_rp_aw", rp_aw, wvec[k].aw);
      chk("idle_rp_dw", rp_dw, wvec[k].dw);
      tick();
      chk("idle_no_rej", wr_rej, 0);
    end
    h_we = 1'b0;

    // Host write during RUN is dropped and reported one cycle later
    req_rnd = 1'b1;
    tick();
    chk("rnd_ack", ack_rnd, 1);
    req_rnd = 1'b0;
    tick();
    chk("rnd_mode", dec_mode, 0);
    h_we = 1'b1; h_aw = 10'd5; h_dw = 32'hA5A5A5A5;
    #1;
    chk("run_rp_we", rp_we, 0);
    chk("run_rp_aw", rp_aw, 5);
    chk("run_rej_not_yet", wr_rej, 0);
    tick();
    chk("run_wr_rej", wr_rej, 1);
    h_we = 1'b0;
    dec_done = 1'b1;
    tick();
    chk("run_rej_clear", wr_rej, 0);
    chk("rnd_fin", fin_rnd, 1);
    dec_done = 1'b0;
    tick();

    // Write in the grant cycle is accepted; then reset mid-RUN aborts the job
    req_rq = 1'b1; h_we = 1'b1;
    #1;
    chk("grant_cycle_rp_we", rp_we, 1);
    tick();
    chk("grant_cycle_ack", ack_rq, 1);
    chk("grant_cycle_no_rej", wr_rej, 0);
    req_rq = 1'b0; h_we = 1'b0;
    tick(); tick(); tick();
    chk("midrun_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_start", dec_start, 0);
    chk("abort_no_fin", fin_rq | fin_rnd, 0);
    tick();
    chk("abort_no_fin2", fin_rq | fin_rnd, 0);
    req_rnd = 1'b1;
    run_job(1'b0, 4, 1'b1);

    // done held high from before the grant is ignored until RUN
    dec_done = 1'b1;
    tick(); tick();
    chk("done_idle_ignored", busy | fin_rq | fin_rnd, 0);
    req_rq = 1'b1;
    tick();
    chk("held_ack", ack_rq, 1);
    req_rq = 1'b0;
    tick();
    chk("held_start", dec_start, 1);
    chk("held_no_fin_start", fin_rq, 0);
    tick();
    chk("held_fin", fin_rq, 1);
    chk("held_lat", last_lat, 1);
    dec_done = 1'b0;
    tick();
    chk("held_idle", busy, 0);

    // Timeout on dut_b (limit 16) with done never asserted
    rst_b = 1'b0;
    tick();
    chk("b_rst_err", b_err, 0);
    req_rnd = 1'b1;
    tick();
    chk("b_ack", b_ack_rnd, 1);
    req_rnd = 1'b0;
    tick();
    chk("b_start", b_dec_start, 1);
    for (int i = 1; i < 16; i++) tick();
    chk("b_no_err_yet", b_err, 0);
    tick();
    chk("b_err", b_err, 1);
    chk("b_busy", b_busy, 1);
    req_rnd = 1'b1; h_we = 1'b1;
    #1;
    chk("b_err_rp_we", b_rp_we, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_no_ack", b_ack_rnd | b_ack_rq, 0);
      chk("b_err_sticky", b_err & b_busy, 1);
    end
    chk("b_err_rej", b_wr_rej, 1);
    h_we = 1'b0;
    rst_b = 1'b1;
    tick();
    chk("b_rst_clears_err", b_err | b_busy, 0);
    rst_b = 1'b0;
    tick();
    chk("b_ack_after_rst", b_ack_rnd, 1);
    chk("b_mode_after_rst", b_dec_mode, 0);
    req_rnd = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
